instr_fetch_unit: RTL and testbench

//  Front-end fetch stage between the Sysbus and instruction decode. It issues
//  64-byte line reads on the bus and buffers the 8x64-bit response beats. It

---
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch front end: requests 64-byte lines on the Sysbus, buffers the eight
// response beats and streams 32-bit instructions with their PCs to decode.
module instr_fetch_unit #(
    parameter int                     BUS_DATA_WIDTH = 64,
    parameter int                     BUS_TAG_WIDTH  = 13,
    parameter int                     LINE_BEATS     = 8,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG     = 13'b1000100000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      inst_valid,
    output logic [31:0]               inst,
    output logic [63:0]               inst_pc,
    input  logic                      inst_ready,
    output logic                      halt,
    output logic [1:0]                dbg_state_o
);

    typedef enum logic [1:0] {S_REQ = 2'd0, S_RESP = 2'd1, S_DRAIN = 2'd2, S_HALT = 2'd3} state_e;

    state_e                    state_q;
    logic [63:0]               pc_q;
    logic [2:0]                beat_cnt_q;
    logic                      discard_q;
    logic [BUS_DATA_WIDTH-1:0] buf_q [LINE_BEATS];

    logic [BUS_DATA_WIDTH-1:0] sel_beat;
    logic [31:0]               slot_word;
    logic [63:0]               redirect_pc_al;
    logic                      word_zero;
    logic                      unused_ok;

    // Slot 2k is the low half of beat k, slot 2k+1 the high half.
    assign sel_beat       = buf_q[pc_q[5:3]];
    assign slot_word      = pc_q[2] ? sel_beat[63:32] : sel_beat[31:0];
    assign word_zero      = (slot_word == 32'd0);
    assign redirect_pc_al = {redirect_pc[63:2], 2'b00};
    assign unused_ok      = ^{bus_resptag, redirect_pc[1:0]};

    assign bus_reqcyc  = (state_q == S_REQ) && !reset;
    assign bus_req     = {pc_q[63:6], 6'b0};
    assign bus_reqtag  = READ_TAG;
    assign bus_respack = (state_q == S_RESP) && bus_respcyc && !reset;
    assign inst_valid  = (state_q == S_DRAIN) && !word_zero && !reset;
    assign inst        = slot_word;
    assign inst_pc     = pc_q;
    assign halt        = (state_q == S_HALT) && !reset;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= entry;
            state_q    <= S_REQ;
            beat_cnt_q <= 3'd0;
            discard_q  <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc_al;
                    end
                    // An ack in the redirect cycle means the stale line is
                    // already in flight; take its beats and throw them away.
                    if (bus_reqack) begin
                        state_q   <= S_RESP;
                        discard_q <= redirect_valid;
                    end
                end
                S_RESP: begin
                    if (redirect_valid) begin
                        pc_q      <= redirect_pc_al;
                        discard_q <= 1'b1;
                    end
                    if (bus_respcyc) begin
                        buf_q[beat_cnt_q] <= bus_resp;
                        beat_cnt_q        <= beat_cnt_q + 3'd1;
                        if (beat_cnt_q == 3'(LINE_BEATS - 1)) begin
                            state_q   <= (discard_q || redirect_valid) ? S_REQ : S_DRAIN;
                            discard_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc_al;
                        state_q <= S_REQ;
                    end else if (word_zero) begin
                        state_q <= S_HALT;
                    end else if (inst_ready) begin
                        pc_q <= pc_q + 64'd4;
                        if (pc_q[5:2] == 4'd15) begin
                            state_q <= S_REQ;
                        end
                    end
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scripted bus agent feeds lines and
// every observable output is checked against hand-derived values.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        halt;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [63:0] line_d [8];

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .bus_respack    (bus_respack),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .halt           (halt),
        .dbg_state_o    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [7:0] tag, input logic [3:0] slot);
        return {8'hC0, tag, 12'h0AB, slot};
    endfunction

    task automatic build_line(input logic [7:0] tag);
        for (int k = 0; k < 8; k++) begin
            line_d[k] = {wd(tag, 4'(2 * k + 1)), wd(tag, 4'(2 * k))};
        end
    endtask

    // Called one step after a clock edge with the DUT in REQ.
    task automatic req_phase(input logic [63:0] addr, input int wait_cycles);
        chk("reqcyc", {63'd0, bus_reqcyc}, 64'd1);
        chk("req_addr", bus_req, addr);
        chk("req_tag", {51'd0, bus_reqtag}, 64'h1100);
        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            chk("req_hold_cyc", {63'd0, bus_reqcyc}, 64'd1);
            chk("req_hold_addr", bus_req, addr);
        end
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        settle();
        chk("reqcyc_drop", {63'd0, bus_reqcyc}, 64'd0);
    endtask

    task automatic send_beats(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = line_d[i];
            settle();
            chk("respack", {63'd0, bus_respack}, 64'd1);
            tick();
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic drain(input logic [63:0] pc0, input int n);
        logic [63:0] pc;
        logic [63:0] beat;
        logic [31:0] exp_word;
        inst_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            pc       = pc0 + 64'(4 * i);
            beat     = line_d[pc[5:3]];
            exp_word = pc[2] ? beat[63:32] : beat[31:0];
            settle();
            chk("inst_valid", {63'd0, inst_valid}, 64'd1);
            chk("inst_pc", inst_pc, pc);
            chk("inst", {32'd0, inst}, {32'd0, exp_word});
            tick();
        end
    endtask

    initial begin
        reset          = 1'b1;
        entry          = 64'h1000;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b1;
        bus_resp       = 64'd0;
        bus_resptag    = 13'h0;
        inst_ready     = 1'b0;

        // Reset: outputs quiet even with a response beat on the bus.
        tick();
        tick();
        chk("rst_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
        chk("rst_respack", {63'd0, bus_respack}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);

        // 1: aligned entry, full line, sixteen instructions, next line.
        reset       = 1'b0;
        bus_respcyc = 1'b0;
        settle();
        req_phase(64'h1000, 2);
        build_line(8'h01);
        send_beats(0, 7);
        drain(64'h1000, 16);
        settle();
        chk("t1_inst_valid_after", {63'd0, inst_valid}, 64'd0);
        chk("t1_next_req", bus_req, 64'h1040);
        chk("t1_next_reqcyc", {63'd0, bus_reqcyc}, 64'd1);

        // 2/3: unaligned entry, then decode stalls for five cycles.
        reset = 1'b1;
        entry = 64'h1008;
        tick();
        reset = 1'b0;
        settle();
        req_phase(64'h1000, 0);
        build_line(8'h02);
        send_beats(0, 7);
        settle();
        chk("t2_first_word", {32'd0, inst}, {32'd0, line_d[1][31:0]});
        drain(64'h1008, 1);
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_stall_valid", {63'd0, inst_valid}, 64'd1);
            chk("t3_stall_pc", inst_pc, 64'h100C);
            chk("t3_stall_inst", {32'd0, inst}, {32'd0, line_d[1][63:32]});
            chk("t3_stall_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
            tick();
        end
        drain(64'h100C, 13);
        settle();
        chk("t2_next_req", bus_req, 64'h1040);

        // 4: redirect arrives with beat 3; rest of the line is discarded.
        req_phase(64'h1040, 0);
        build_line(8'h04);
        send_beats(0, 2);
        bus_respcyc    = 1'b1;
        bus_resp       = line_d[3];
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2006;
        settle();
        chk("t4_redir_respack", {63'd0, bus_respack}, 64'd1);
        tick();
        redirect_valid = 1'b0;
        send_beats(4, 7);
        settle();
        chk("t4_no_inst", {63'd0, inst_valid}, 64'd0);
        req_phase(64'h2000, 1);
        build_line(8'h05);
        send_beats(0, 7);
        drain(64'h2004, 2);

        // Redirect during drain beats the same-cycle handshake.
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        tick();
        redirect_valid = 1'b0;
        settle();
        req_phase(64'h3000, 0);

        // 5: slot 5 holds a zero word -> halt after slots 0..4.
        build_line(8'h06);
        line_d[2][63:32] = 32'd0;
        send_beats(0, 7);
        drain(64'h3000, 5);
        settle();
        chk("t5_zero_not_valid", {63'd0, inst_valid}, 64'd0);
        tick();
        chk("t5_halt", {63'd0, halt}, 64'd1);
        chk("t5_halt_state", {62'd0, dbg_state}, 64'd3);
        chk("t5_halt_valid", {63'd0, inst_valid}, 64'd0);
        chk("t5_halt_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        tick();
        tick();
        tick();
        redirect_valid = 1'b0;
        chk("t5_halt_sticky", {63'd0, halt}, 64'd1);
        chk("t5_halt_no_req", {63'd0, bus_reqcyc}, 64'd0);

        // 6: reset leaves halt, then reset again in the middle of a response.
        reset = 1'b1;
        entry = 64'h5000;
        settle();
        chk("t6_rst_halt", {63'd0, halt}, 64'd0);
        tick();
        reset = 1'b0;
        settle();
        req_phase(64'h5000, 0);
        build_line(8'h07);
        send_beats(0, 2);
        reset       = 1'b1;
        entry       = 64'h3000;
        bus_respcyc = 1'b1;
        settle();
        chk("t6_rst_respack", {63'd0, bus_respack}, 64'd0);
        chk("t6_rst_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
        chk("t6_rst_valid", {63'd0, inst_valid}, 64'd0);
        tick();
        chk("t6_rst_respack2", {63'd0, bus_respack}, 64'd0);
        chk("t6_rst_reqcyc2", {63'd0, bus_reqcyc}, 64'd0);
        tick();
        reset       = 1'b0;
        bus_respcyc = 1'b0;
        settle();
        req_phase(64'h3000, 0);
        send_beats(0, 7);
        drain(64'h3000, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
